// File: rtl/quad_enc_dec_pkg.sv
// Shared quadrature-phase definitions and the transition classifier used by
// the decoder (and any future encoder model).
package QuadEnc;

   typedef enum logic [1:0] {
      PH00 = 2'b00,
      PH01 = 2'b01,
      PH10 = 2'b10,
      PH11 = 2'b11
   } phase_t;

   // Returns {fwd, rev, illegal}. Forward order is 00->10->11->01->00,
   // i.e. next = {~B, A}; any single-bit change that is not forward is reverse.
   function automatic logic [2:0] step_dir(input phase_t prev, input phase_t cur);
      logic [1:0] w_p;
      logic [1:0] w_c;
      logic [1:0] w_fwd_next;
      logic [2:0] w_res;
      w_p        = prev;
      w_c        = cur;
      w_fwd_next = {~w_p[0], w_p[1]};
      w_res      = 3'b000;
      if (w_p == w_c)
         w_res = 3'b000;
      else if ((w_p ^ w_c) == 2'b11)
         w_res = 3'b001;
      else if (w_c == w_fwd_next)
         w_res = 3'b100;
      else
         w_res = 3'b010;
      return w_res;
   endfunction

endpackage

// File: rtl/quad_enc_dec_glitch_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output only
// follows the synchronized input after it has differed for FILT_CYC cycles.
module glitch_filter #(
   parameter int FILT_CYC = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   localparam int FC_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYC - 1);

   logic            r_s1;
   logic            r_s2;
   logic            r_q;
   logic [FC_W-1:0] r_fc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_q  <= 1'b0;
         r_fc <= '0;
      end else begin
         r_s1 <= d;
         r_s2 <= r_s1;
         // Any return to the accepted value restarts the persistence count.
         if (r_s2 == r_q) begin
            r_fc <= '0;
         end else if (r_fc == FC_LAST) begin
            r_q  <= r_s2;
            r_fc <= '0;
         end else begin
            r_fc <= r_fc + 1'b1;
         end
      end
   end

   assign q = r_q;

endmodule

// File: rtl/quad_enc_dec.sv
// Quadrature decoder top: filtered A/B, 4x transition decode, wrapping signed
// position counter with one-cycle step/error pulses and a sticky error flag.
module quad_enc_dec
   import QuadEnc::*;
#(
   parameter int CNT_W    = 16,
   parameter int FILT_CYC = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a,
   input  logic                    b,
   input  logic                    clr,
   output logic signed [CNT_W-1:0] pos,
   output logic                    inc,
   output logic                    dec,
   output logic                    err,
   output logic                    err_flag
);

   logic       w_a_f;
   logic       w_b_f;
   phase_t     w_cur;
   logic [2:0] w_dir;

   phase_t                  r_prev;
   logic signed [CNT_W-1:0] r_pos;
   logic                    r_inc;
   logic                    r_dec;
   logic                    r_err;
   logic                    r_err_flag;

   glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt_a (
      .clk (clk),
      .rst (rst),
      .d   (a),
      .q   (w_a_f)
   );

   glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt_b (
      .clk (clk),
      .rst (rst),
      .d   (b),
      .q   (w_b_f)
   );

   assign w_cur = phase_t'({w_a_f, w_b_f});
   assign w_dir = step_dir(r_prev, w_cur);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_prev     <= PH00;
         r_pos      <= '0;
         r_inc      <= 1'b0;
         r_dec      <= 1'b0;
         r_err      <= 1'b0;
         r_err_flag <= 1'b0;
      end else begin
         r_prev <= w_cur;
         r_inc  <= w_dir[2];
         r_dec  <= w_dir[1];
         r_err  <= w_dir[0];
         // clr wins over a coincident step; the pulse itself is still reported.
         if (clr) begin
            r_pos      <= '0;
            r_err_flag <= 1'b0;
         end else begin
            if (w_dir[2])
               r_pos <= r_pos + CNT_W'(1);
            else if (w_dir[1])
               r_pos <= r_pos - CNT_W'(1);
            if (w_dir[0])
               r_err_flag <= 1'b1;
         end
      end
   end

   assign pos      = r_pos;
   assign inc      = r_inc;
   assign dec      = r_dec;
   assign err      = r_err;
   assign err_flag = r_err_flag;

endmodule
